// File: rtl/intc_if.sv
// Bus and interrupt signal bundle for the interrupt controller.
// The master side (bus host and interrupt sources) drives data_i, addr_i,
// we_i and src_i. The slave side (intc) drives data_o, int_sig_o and
// int_id_o.
interface intc_if #(
    parameter int N_SRC = 8
);
    logic [31:0]      data_i;
    logic [31:0]      addr_i;
    logic             we_i;
    logic [31:0]      data_o;
    logic [N_SRC-1:0] src_i;
    logic             int_sig_o;
    logic [2:0]       int_id_o;

    modport master (
        output data_i, addr_i, we_i, src_i,
        input  data_o, int_sig_o, int_id_o
    );

    modport slave (
        input  data_i, addr_i, we_i, src_i,
        output data_o, int_sig_o, int_id_o
    );
endinterface

// File: rtl/intc.sv
// Interrupt controller: 8 level-sensitive sources, fixed priority (bit 0 is
// the highest priority), and one interrupt in service at a time.
// Register map (decoded on addr_i[3:0]):
//   0x0 PEND  (ro) pending bits [7:0]
//   0x4 EN    (rw) per-source enables [7:0]
//   0x8 CLAIM read : {busy, 28'b0, id}; write : complete the ID in data_i[2:0]
//   0xC CTRL  (rw) bit 0 = global dispatch enable
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - intc_if.slave: data_i/addr_i/we_i bus write, data_o bus read,
//          src_i requests, int_sig_o/int_id_o interrupt to the core
module intc #(
    parameter int N_SRC = 8
) (
    input  logic  clk,
    input  logic  rst,
    intc_if.slave bus
);

    localparam logic [3:0] ADDR_PEND  = 4'h0;
    localparam logic [3:0] ADDR_EN    = 4'h4;
    localparam logic [3:0] ADDR_CLAIM = 4'h8;
    localparam logic [3:0] ADDR_CTRL  = 4'hC;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t           state_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] en_r;
    logic             ctrl_r;
    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] insvc_r;
    logic [2:0]       cur_id_r;
    logic             int_sig_r;
    logic [2:0]       int_id_r;

    logic [N_SRC-1:0] pend_set_s;
    logic [N_SRC-1:0] ready_s;
    logic [2:0]       next_id_s;
    logic [N_SRC-1:0] next_mask_s;
    logic [N_SRC-1:0] cur_mask_s;
    logic             claim_hit_s;
    logic [31:0]      rdata_s;
    logic             unused_bits_s;

    // Lowest-index set bit of v; returns 0 when v is empty.
    function automatic logic [2:0] lowest_id(input logic [N_SRC-1:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

    // One-hot mask for a source ID.
    function automatic logic [N_SRC-1:0] id_mask(input logic [2:0] id);
        return {{(N_SRC-1){1'b0}}, 1'b1} << id;
    endfunction

    // Only the low address nibble and the low data byte carry meaning.
    assign unused_bits_s = ^{bus.addr_i[31:4], bus.data_i[31:N_SRC]};

    // Dispatch selection and completion decode from the current register state.
    always_comb begin
        // A source in service cannot re-pend until its insvc bit has cleared.
        pend_set_s  = src_q_r & ~insvc_r;
        ready_s     = pend_r & en_r;
        next_id_s   = lowest_id(ready_s);
        next_mask_s = id_mask(next_id_s);
        cur_mask_s  = id_mask(cur_id_r);
        claim_hit_s = bus.we_i && (bus.addr_i[3:0] == ADDR_CLAIM)
                      && (bus.data_i[2:0] == cur_id_r);
    end

    // Input synchronisation register and the software-writable EN/CTRL registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q_r <= '0;
            en_r    <= '0;
            ctrl_r  <= 1'b0;
        end else begin
            src_q_r <= bus.src_i;
            if (bus.we_i && (bus.addr_i[3:0] == ADDR_EN)) begin
                en_r <= bus.data_i[N_SRC-1:0];
            end else begin
                en_r <= en_r;
            end
            if (bus.we_i && (bus.addr_i[3:0] == ADDR_CTRL)) begin
                ctrl_r <= bus.data_i[0];
            end else begin
                ctrl_r <= ctrl_r;
            end
        end
    end

    // Dispatch FSM: owns PEND, insvc, cur_id and the registered interrupt outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pend_r    <= '0;
            insvc_r   <= '0;
            cur_id_r  <= 3'd0;
            int_sig_r <= 1'b0;
            int_id_r  <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    // EN/CTRL writes in this cycle land on the same edge, so the
                    // decision naturally uses the old register values.
                    if (ctrl_r && (ready_s != '0)) begin
                        // Set-then-clear: the dispatched bit must end up clear
                        // even if its source is still high this cycle.
                        pend_r    <= (pend_r | pend_set_s) & ~next_mask_s;
                        insvc_r   <= insvc_r | next_mask_s;
                        cur_id_r  <= next_id_s;
                        int_sig_r <= 1'b1;
                        int_id_r  <= next_id_s;
                        state_r   <= SERVE;
                    end else begin
                        pend_r    <= pend_r | pend_set_s;
                        int_sig_r <= 1'b0;
                        int_id_r  <= 3'd0;
                        state_r   <= IDLE;
                    end
                end
                SERVE: begin
                    // Service is only ended by a matching completion; EN/CTRL
                    // changes here merely gate future dispatches.
                    pend_r <= pend_r | pend_set_s;
                    if (claim_hit_s) begin
                        insvc_r   <= insvc_r & ~cur_mask_s;
                        int_sig_r <= 1'b0;
                        int_id_r  <= 3'd0;
                        state_r   <= IDLE;
                    end else begin
                        int_sig_r <= 1'b1;
                        int_id_r  <= cur_id_r;
                        state_r   <= SERVE;
                    end
                end
                default: begin
                    pend_r    <= '0;
                    insvc_r   <= '0;
                    int_sig_r <= 1'b0;
                    int_id_r  <= 3'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; forced to zero while reset is held.
    always_comb begin
        rdata_s = 32'd0;
        if (rst) begin
            rdata_s = 32'd0;
        end else begin
            case (bus.addr_i[3:0])
                ADDR_PEND:  rdata_s = 32'(pend_r);
                ADDR_EN:    rdata_s = 32'(en_r);
                ADDR_CLAIM: rdata_s = {(state_r == SERVE), 28'd0, cur_id_r};
                ADDR_CTRL:  rdata_s = {31'd0, ctrl_r};
                default:    rdata_s = 32'd0;
            endcase
        end
    end

    assign bus.data_o    = rdata_s;
    assign bus.int_sig_o = int_sig_r;
    assign bus.int_id_o  = int_id_r;

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (fixed at 8 for this revision; IDs are 3 bits).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_i  input  32  bus write data.
REQ-005 addr_i  input  32  bus address; only addr_i[3:0] is decoded.
REQ-006 we_i  input  1  bus write enable, active-high.
REQ-007 data_o  output  32  bus read data, combinational from addr_i[3:0].
REQ-008 src_i  input  8  level interrupt requests, e.g. the timer int_sig_o on bit 0; synchronous to clk.
REQ-009 int_sig_o  output  1  interrupt request to the core, active-high.
REQ-010 int_id_o  output  3  ID of the source in service.

Function
REQ-011 The register map SHALL be: 0x0 PEND, 0x4 EN, 0x8 CLAIM, 0xC CTRL; other offsets read 0 and ignore writes.
REQ-012 PEND[7:0] SHALL be read-only pending bits; bits [31:8] read 0; writes are ignored.
REQ-013 EN[7:0] SHALL be read/write per-source enables; bits [31:8] read 0.
REQ-014 CTRL[0] SHALL be read/write global dispatch enable; bits [31:1] read 0.
REQ-015 A CLAIM read SHALL return {busy, 28'b0, id[2:0]}, with busy in bit 31 and the other bits 0; reads have no side effects.
REQ-016 A CLAIM write SHALL be a completion request carrying the ID in data_i[2:0].
REQ-017 src_i SHALL be registered once (src_q) before use.
REQ-018 PEND[i] SHALL set when src_q[i]=1 and insvc[i]=0.
REQ-019 PEND[i] SHALL clear only when source i is dispatched; a source deasserting before dispatch leaves PEND[i] set.
REQ-020 The FSM SHALL have two states, IDLE and SERVE.
REQ-021 In IDLE, when CTRL[0]=1 and (PEND & EN)!=0, the block SHALL dispatch on the next edge: choose the lowest-index set bit (bit 0 highest priority), latch it as cur_id, clear that PEND bit, set insvc[cur_id], and enter SERVE.
REQ-022 In SERVE, int_sig_o=1 and int_id_o=cur_id SHALL hold every cycle; in IDLE, int_sig_o=0 and int_id_o=0.
REQ-023 In SERVE, a CLAIM write with data_i[2:0]==cur_id SHALL clear insvc[cur_id] and return the FSM to IDLE on that edge.
REQ-024 A mismatched-ID CLAIM write, or any CLAIM write in IDLE, SHALL be ignored.
REQ-025 Latency SHALL be: src_i rises in cycle n -> src_q in n+1 -> PEND set in n+2 -> SERVE and int_sig_o=1 in n+3 (when enabled and IDLE).
REQ-026 After completion, the next dispatch SHALL occur no earlier than the following cycle; there is at least one IDLE cycle between services.
REQ-027 A source still high after completion SHALL re-pend one cycle after insvc clears.
REQ-028 Clearing CTRL[0] or EN[cur_id] during SERVE SHALL NOT abort service; it only blocks new dispatches.
REQ-029 A write to EN or CTRL in the same cycle as a dispatch decision SHALL NOT affect that decision; the old values are used.
REQ-030 A completion and a new PEND set in the same cycle SHALL both take effect.

Reset
REQ-031 While rst=1, on the clock edge: PEND, EN, CTRL, src_q, insvc and cur_id SHALL reset to 0 and the FSM to IDLE.
REQ-032 While rst=1, data_o SHALL read 0.
REQ-033 Out of reset, int_sig_o=0 and int_id_o=0.
REQ-034 Reset asserted during SERVE SHALL drop int_sig_o on the next edge and discard all pending state.

Verification
REQ-035 Single source: CTRL=1, EN=0x01, src_i[0]=1 at cycle n -> int_sig_o=1 and int_id_o=0 at n+3; CLAIM read = 0x80000000; write CLAIM=0 -> int_sig_o=0 next cycle.
REQ-036 Priority: EN=0xFF, src_i=0x24 together -> ID 2 served first; after completing 2, ID 5 served; CLAIM reads 0x80000002 then 0x80000005.
REQ-037 Masking: EN=0x00, src_i[3]=1 -> PEND=0x08 and int_sig_o stays 0; write EN=0x08 -> int_sig_o=1 with ID 3 after 1 cycle.
REQ-038 Mismatch and re-pend: in SERVE with ID 1, write CLAIM=4 -> still SERVE; write CLAIM=1 with src_i[1] still high -> re-dispatch of ID 1 within 3 cycles.
REQ-039 Global disable: CTRL=0 with PEND&EN!=0 -> no dispatch; CTRL cleared mid-SERVE -> int_sig_o held until completion.
REQ-040 Reset mid-SERVE: rst=1 for 1 cycle -> int_sig_o=0, PEND=EN=CTRL=0, CLAIM read 0 after release.
